// File: rtl/cal_avg_pkg.sv
// cal_avg_pkg: shared constants and FSM state type for the average FIFO reader
package cal_avg_pkg;
  localparam int CAL_AVG_DATA_WIDTH = 26;
  localparam int CAL_AVG_FIFO_DEPTH = 512;
  localparam int CAL_AVG_READ_LATENCY = 2;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} cal_avg_state_e;
endpackage

// File: rtl/cal_avg_out_buf.sv
// cal_avg_out_buf: small circular buffer absorbing the FIFO read latency in front of the stream
module cal_avg_out_buf
  import cal_avg_pkg::*;
#(
  parameter int WIDTH = CAL_AVG_DATA_WIDTH,
  parameter int DEPTH = CAL_AVG_READ_LATENCY + 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop, full;
  assign empty_o = count_q == '0;
  assign full    = count_q == CW'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  // Pointer wrap and occupancy update; push and pop may coincide
  always_comb begin
    wr_d    = push_i ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = do_pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    count_d = count_q + CW'(push_i) - CW'(do_pop);
  end
  // Pointers and count; clear empties the buffer without touching storage
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // Storage write; contents only matter while counted as occupied
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  // Issue throttling upstream guarantees a push never lands on a full buffer without a pop
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i || clr_i) push_i && full |-> do_pop);
endmodule

// File: rtl/cal_average_fifo_reader.sv
// cal_average_fifo_reader: drains one frame from the averaging FIFO as a valid/ready stream
module cal_average_fifo_reader
  import cal_avg_pkg::*;
#(
  parameter int DATA_WIDTH   = CAL_AVG_DATA_WIDTH,
  parameter int READ_LATENCY = CAL_AVG_READ_LATENCY,
  parameter int LEN_WIDTH    = 10,
  parameter int BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [LEN_WIDTH-1:0]  FRAME_LEN,
  output logic                  FIFO_RE,
  input  logic [DATA_WIDTH-1:0] FIFO_Q,
  input  logic                  FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_FIRST,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  cal_avg_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0]     issue_q, issue_d, out_q, out_d, len_q, len_d;
  logic [READ_LATENCY-1:0]  pipe_q, pipe_d;
  logic [CW-1:0]            buf_count, inflight;
  logic [CW:0]              occ;
  logic [DATA_WIDTH-1:0]    head;
  logic                     buf_empty, abort_go, pop;
  assign abort_go  = ABORT && state_q != S_IDLE;
  assign occ       = {1'b0, buf_count} + {1'b0, inflight};
  assign FIFO_RE   = state_q == S_READ && !ABORT && !FIFO_EMPTY && issue_q != '0 && occ < (CW + 1)'(BUF_DEPTH);
  assign OUT_VALID = !buf_empty;
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_DATA  = OUT_VALID ? head : '0;
  assign OUT_FIRST = OUT_VALID && out_q == len_q;
  assign OUT_LAST  = OUT_VALID && out_q == LEN_WIDTH'(1);
  assign BUSY      = state_q != S_IDLE;
  assign DONE      = state_q == S_FIN && !ABORT;
  // Words still travelling through the FIFO read pipe count against buffer space
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pipe_q[i]);
  end
  // Frame sequencing; abort wipes counters and the in-flight pipe
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    out_d   = pop ? out_q - 1'b1 : out_q;
    len_d   = len_q;
    pipe_d  = (pipe_q << 1) | READ_LATENCY'(FIFO_RE);
    if (abort_go) begin
      state_d = S_IDLE;
      issue_d = '0;
      out_d   = '0;
      len_d   = '0;
      pipe_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          issue_d = FRAME_LEN;
          out_d   = FRAME_LEN;
          len_d   = FRAME_LEN;
          state_d = (FRAME_LEN == '0) ? S_FIN : S_READ;
        end
        S_READ: if (FIFO_RE) begin
          issue_d = issue_q - 1'b1;
          state_d = (issue_q == LEN_WIDTH'(1)) ? S_DRAIN : S_READ;
        end
        S_DRAIN: state_d = (pop && out_q == LEN_WIDTH'(1)) ? S_FIN : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      out_q   <= '0;
      len_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      out_q   <= out_d;
      len_q   <= len_d;
      pipe_q  <= pipe_d;
    end
  end
  cal_avg_out_buf #(.WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
    .clk_i   (CLK),
    .rst_n_i (RESET_N),
    .clr_i   (abort_go),
    .push_i  (pipe_q[READ_LATENCY-1]),
    .data_i  (FIFO_Q),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (buf_count),
    .empty_o (buf_empty)
  );
endmodule
